// File: rtl/harvard_test_mem_pkg.sv
// Shared constants and helpers for the Harvard test memory.
// Reset vector, byte-lane geometry, fault flag positions.
package harvard_test_mem_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam int LANE_W = 8;
  localparam int LANES = 4;
  localparam int FAULT_INSTR = 0;
  localparam int FAULT_DATA = 1;

  function automatic logic [31:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/word_store.sv
// Word-wide store: async read, byte-enabled write,
// and an auto-incrementing load pointer with wrap flag.
module word_store
  import harvard_test_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        rd_idx,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_idx,
  input  logic [LANES-1:0]     wr_be,
  input  logic [31:0]          wr_data,
  input  logic                 ld_en,
  input  logic [31:0]          ld_data,
  output logic                 wrapped
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ptr;

  assign rd_data = mem[rd_idx];

  // Load pointer and sticky wrap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      wrapped <= 1'b0;
    end else if (ld_en) begin
      ptr <= ptr + 1'b1;
      if (ptr == AW'(DEPTH - 1))
        wrapped <= 1'b1;
    end
  end

  // Contents are never reset; load has priority over CPU write
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ptr] <= ld_data;
    end else if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_be[b])
          mem[wr_idx][b*LANE_W +: LANE_W] <= wr_data[b*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/harvard_test_mem.sv
// Harvard test memory: separate instruction and data stores
// with a serial loader, sticky fault flags and a write counter.
module harvard_test_mem
  import harvard_test_mem_pkg::*;
#(
  parameter int          INSTR_WORDS = 256,
  parameter int          DATA_WORDS = 256,
  parameter logic [31:0] INSTR_BASE = RESET_VECTOR,
  parameter logic [31:0] DATA_BASE = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_mem,
  input  logic        init_sel,
  input  logic [31:0] init_word,
  output logic [1:0]  init_full,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [1:0]  fault,
  output logic [15:0] write_count
);

  localparam int IAW = $clog2(INSTR_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);

  logic [31:0] i_widx;
  logic [31:0] d_widx;
  logic        i_ok;
  logic        d_ok;
  logic [31:0] i_rd;
  logic [31:0] d_rd;
  logic        i_ld;
  logic        d_ld;
  logic        d_wr;
  logic        i_wrap;
  logic        d_wrap;

  assign i_widx = word_index(instr_address, INSTR_BASE);
  assign d_widx = word_index(data_address, DATA_BASE);
  assign i_ok = (instr_address[1:0] == 2'b00) &&
                (i_widx < 32'(INSTR_WORDS));
  assign d_ok = (data_address[1:0] == 2'b00) &&
                (d_widx < 32'(DATA_WORDS));

  assign i_ld = init_mem && !reset && !init_sel;
  assign d_ld = init_mem && !reset && init_sel;
  assign d_wr = data_write && d_ok && !init_mem && !reset;

  assign instr_readdata = i_ok ? i_rd : 32'h0;
  assign data_readdata = (data_read && d_ok) ? d_rd : 32'h0;
  assign init_full = {d_wrap, i_wrap};

  word_store #(.DEPTH(INSTR_WORDS)) u_istore (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (i_widx[IAW-1:0]),
    .rd_data (i_rd),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_be   ('0),
    .wr_data ('0),
    .ld_en   (i_ld),
    .ld_data (init_word),
    .wrapped (i_wrap)
  );

  word_store #(.DEPTH(DATA_WORDS)) u_dstore (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (d_widx[DAW-1:0]),
    .rd_data (d_rd),
    .wr_en   (d_wr),
    .wr_idx  (d_widx[DAW-1:0]),
    .wr_be   (data_byteenable),
    .wr_data (data_writedata),
    .ld_en   (d_ld),
    .ld_data (init_word),
    .wrapped (d_wrap)
  );

  // Sticky fault flags and saturating count of accepted CPU writes
  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 2'b00;
      write_count <= 16'h0;
    end else begin
      if (!i_ok)
        fault[FAULT_INSTR] <= 1'b1;
      if (((data_read || data_write) && !d_ok) ||
          (data_read && data_write))
        fault[FAULT_DATA] <= 1'b1;
      if (d_wr && write_count != 16'hFFFF)
        write_count <= write_count + 16'h1;
    end
  end

endmodule

// File: tb/tb_harvard_test_mem.sv
// Directed + random bench for harvard_test_mem against a
// behavioural model of the stores, loaders, faults and counter.
module tb_harvard_test_mem;

  localparam int IW = 4;
  localparam int DW = 16;
  localparam logic [31:0] IB = 32'hBFC00000;
  localparam logic [31:0] DB = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        init_mem;
  logic        init_sel;
  logic [31:0] init_word;
  logic [1:0]  init_full;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [1:0]  fault;
  logic [15:0] write_count;

  int n_assert = 0;
  int n_fail = 0;

  logic [31:0] im [IW];
  logic [31:0] dm [DW];
  int          iptr;
  int          dptr;
  logic [1:0]  mfull;
  logic [1:0]  mfault;
  int          mwc;

  harvard_test_mem #(
    .INSTR_WORDS (IW),
    .DATA_WORDS  (DW),
    .INSTR_BASE  (IB),
    .DATA_BASE   (DB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .init_mem        (init_mem),
    .init_sel        (init_sel),
    .init_word       (init_word),
    .init_full       (init_full),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_byteenable (data_byteenable),
    .data_writedata  (data_writedata),
    .data_readdata   (data_readdata),
    .fault           (fault),
    .write_count     (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_rng(logic [31:0] a, logic [31:0] base, int depth);
    logic [31:0] off;
    off = a - base;
    return (a % 4 == 0) && (off / 4 < depth);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the current inputs
  task automatic model_edge();
    bit dok;
    int di;
    dok = in_rng(data_address, DB, DW);
    di = int'((data_address - DB) / 4);
    if (reset) begin
      iptr = 0;
      dptr = 0;
      mfull = 2'b00;
      mfault = 2'b00;
      mwc = 0;
    end else begin
      if (!in_rng(instr_address, IB, IW))
        mfault[0] = 1'b1;
      if ((data_read || data_write) && !dok)
        mfault[1] = 1'b1;
      if (data_read && data_write)
        mfault[1] = 1'b1;
      if (init_mem) begin
        if (!init_sel) begin
          im[iptr] = init_word;
          iptr = (iptr + 1) % IW;
          if (iptr == 0) mfull[0] = 1'b1;
        end else begin
          dm[dptr] = init_word;
          dptr = (dptr + 1) % DW;
          if (dptr == 0) mfull[1] = 1'b1;
        end
      end else if (data_write && dok) begin
        for (int b = 0; b < 4; b++)
          if (data_byteenable[b])
            dm[di][8*b +: 8] = data_writedata[8*b +: 8];
        if (mwc < 65535) mwc = mwc + 1;
      end
    end
  endtask

  // One clock: check reads before the edge, state after it
  task automatic cycle();
    logic [31:0] ei;
    logic [31:0] ed;
    @(negedge clk);
    ei = 32'h0;
    if (in_rng(instr_address, IB, IW))
      ei = im[int'((instr_address - IB) / 4)];
    ed = 32'h0;
    if (data_read && in_rng(data_address, DB, DW))
      ed = dm[int'((data_address - DB) / 4)];
    if (!$isunknown(ei)) chk("instr_rd", instr_readdata, ei);
    if (!$isunknown(ed)) chk("data_rd", data_readdata, ed);
    @(posedge clk);
    model_edge();
    #1;
    chk("init_full", 32'(init_full), 32'(mfull));
    chk("fault", 32'(fault), 32'(mfault));
    chk("write_count", 32'(write_count), 32'(mwc));
  endtask

  task automatic idle();
    reset = 1'b0;
    init_mem = 1'b0;
    init_sel = 1'b0;
    init_word = 32'h0;
    instr_address = IB;
    data_address = DB;
    data_read = 1'b0;
    data_write = 1'b0;
    data_byteenable = 4'h0;
    data_writedata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic load(logic sel, logic [31:0] w);
    init_mem = 1'b1;
    init_sel = sel;
    init_word = w;
    cycle();
    init_mem = 1'b0;
  endtask

  task automatic cpu_write(logic [31:0] a, logic [31:0] w, logic [3:0] be);
    data_write = 1'b1;
    data_address = a;
    data_writedata = w;
    data_byteenable = be;
    cycle();
    data_write = 1'b0;
  endtask

  task automatic peek_d(string tag, logic [31:0] a, logic [31:0] exp);
    data_read = 1'b1;
    data_address = a;
    #1;
    chk(tag, data_readdata, exp);
    data_read = 1'b0;
  endtask

  task automatic peek_i(string tag, logic [31:0] a, logic [31:0] exp);
    instr_address = a;
    #1;
    chk(tag, instr_readdata, exp);
    instr_address = IB;
  endtask

  initial begin
    logic [31:0] old20;
    logic [31:0] wa;
    logic [31:0] wb;
    idle();

    // reset with a load strobe held: must be ignored
    reset = 1'b1;
    init_mem = 1'b1;
    init_word = 32'h12345678;
    cycle();
    cycle();
    idle();
    chk("rst_full", 32'(init_full), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_wc", 32'(write_count), 32'h0);

    // fill both stores so every later read is defined
    for (int i = 0; i < IW; i++) load(1'b0, $urandom);
    for (int i = 0; i < DW; i++) load(1'b1, $urandom);
    chk("fill_full", 32'(init_full), 32'h3);
    do_reset();
    chk("fill_full_rst", 32'(init_full), 32'h0);

    // program load
    load(1'b0, 32'h8C230000);
    load(1'b0, 32'h04410002);
    peek_i("ld_w0", IB, 32'h8C230000);
    peek_i("ld_w1", IB + 4, 32'h04410002);
    chk("ld_fault", 32'(fault), 32'h0);

    // byte-lane write
    cpu_write(DB + 32'h10, 32'hDEADBEEF, 4'b1111);
    cpu_write(DB + 32'h10, 32'h00000055, 4'b0001);
    peek_d("byte_wr", DB + 32'h10, 32'hDEADBE55);
    chk("byte_wc", 32'(write_count), 32'h2);

    // collision: same-cycle read returns old contents
    data_read = 1'b1;
    data_write = 1'b1;
    data_address = DB;
    data_writedata = 32'h11111111;
    data_byteenable = 4'hF;
    #1;
    chk("coll_old", data_readdata, dm[0]);
    cycle();
    data_write = 1'b0;
    #1;
    chk("coll_new", data_readdata, 32'h11111111);
    chk("coll_fault", 32'(fault), 32'h2);
    data_read = 1'b0;
    do_reset();

    // CPU write alongside a load is discarded
    old20 = dm[8];
    init_mem = 1'b1;
    init_sel = 1'b1;
    init_word = 32'hA5A5A5A5;
    cpu_write(DB + 32'h20, 32'hFFFFFFFF, 4'hF);
    init_mem = 1'b0;
    peek_d("disc_data", DB + 32'h20, old20);
    peek_d("disc_load", DB, 32'hA5A5A5A5);
    chk("disc_wc", 32'(write_count), 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      init_mem = ($urandom_range(0, 7) == 0);
      init_sel = 1'($urandom);
      init_word = $urandom;
      instr_address = IB + 4 * $urandom_range(0, IW - 1);
      if ($urandom_range(0, 15) == 0) instr_address = $urandom;
      data_address = DB + 4 * $urandom_range(0, DW - 1);
      if ($urandom_range(0, 9) == 0) data_address = $urandom_range(0, 4 * DW + 8);
      data_read = 1'($urandom);
      data_write = 1'($urandom);
      data_byteenable = 4'($urandom);
      data_writedata = $urandom;
      cycle();
    end
    idle();
    do_reset();

    // out-of-range / misaligned accesses
    peek_i("oor_instr", IB + 2, 32'h0);
    instr_address = IB + 2;
    cycle();
    instr_address = IB;
    chk("oor_f0", 32'(fault), 32'h1);
    peek_d("oor_data", DB + 4 * DW, 32'h0);
    data_read = 1'b1;
    data_address = DB + 4 * DW;
    cycle();
    idle();
    chk("oor_f1", 32'(fault), 32'h3);
    cycle();
    cycle();
    chk("oor_sticky", 32'(fault), 32'h3);
    do_reset();
    chk("oor_clr", 32'(fault), 32'h0);

    // loader wrap
    for (int v = 1; v <= 5; v++) load(1'b0, 32'(v));
    peek_i("wrap_w0", IB, 32'd5);
    peek_i("wrap_w1", IB + 4, 32'd2);
    peek_i("wrap_w2", IB + 8, 32'd3);
    peek_i("wrap_w3", IB + 12, 32'd4);
    chk("wrap_full", 32'(init_full), 32'h1);
    do_reset();

    // reset mid-load restarts at word 0
    cpu_write(DB + 32'h30, 32'h1, 4'h1);
    wa = $urandom;
    wb = $urandom;
    load(1'b1, wa);
    load(1'b1, wb);
    do_reset();
    load(1'b1, 32'hCAFEF00D);
    peek_d("mid_w0", DB, 32'hCAFEF00D);
    peek_d("mid_w1", DB + 4, wb);
    chk("mid_wc", 32'(write_count), 32'h0);

    // counter saturation
    for (int n = 0; n < 65540; n++)
      cpu_write(DB + 4 * $urandom_range(0, DW - 1), $urandom, 4'($urandom));
    chk("sat_wc", 32'(write_count), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/harvard_test_mem.md
HARVARD_TEST_MEM -- requirements
Module: harvard_test_mem

Interface
REQ-001 The block SHALL have parameter INSTR_WORDS, default 256, instruction store depth in 32-bit words (power of two, 4..65536).
REQ-002 The block SHALL have parameter DATA_WORDS, default 256, data store depth in 32-bit words (power of two, 4..65536).
REQ-003 The block SHALL have parameter INSTR_BASE, default 32'hBFC00000, byte address of instruction word 0.
REQ-004 The block SHALL have parameter DATA_BASE, default 32'h00000000, byte address of data word 0.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-006 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- init_mem  in  1  load strobe: one word per cycle.
- init_sel  in  1  load target: 0 = instruction store, 1 = data store.
- init_word  in  32  word to load.
- init_full  out  2  bit0 = instruction load pointer has wrapped, bit1 = data load pointer has wrapped.
- instr_address  in  32  CPU fetch byte address.
- instr_readdata  out  32  fetched word.
- data_address  in  32  CPU data byte address.
- data_read  in  1  CPU data read strobe.
- data_write  in  1  CPU data write strobe.
- data_byteenable  in  4  write byte lanes; bit n enables bits 8n+7..8n.
- data_writedata  in  32  CPU write word.
- data_readdata  out  32  CPU read word.
- fault  out  2  sticky flags: bit0 = instruction fault, bit1 = data fault.
- write_count  out  16  saturating count of accepted CPU writes.

Function
REQ-007 Word index SHALL be (address - base) >> 2. An address is in range iff address[1:0] == 0 and index < depth.
REQ-008 instr_readdata SHALL be combinational from instr_address.
- In range: it SHALL be the stored word.
- Out of range: it SHALL be 32'h0.
REQ-009 data_readdata SHALL be combinational.
- When data_read = 1 and the address is in range: it SHALL be the stored word.
- Otherwise: it SHALL be 32'h0.
REQ-010 A CPU write (data_write = 1, in range, init_mem = 0, reset = 0) SHALL update only the enabled byte lanes at the clock edge.
REQ-011 A same-cycle read of the address being written SHALL return the pre-write contents.
REQ-012 An accepted CPU write with data_byteenable = 0 SHALL change no contents but SHALL still increment write_count.
REQ-013 write_count SHALL saturate at 16'hFFFF.
REQ-014 A CPU write with init_mem = 1 in the same cycle SHALL be discarded: no contents change and no count increment.
REQ-015 Fault flags SHALL be set at the clock edge and held until reset.
- fault[0] SHALL be set on every cycle in which instr_address is out of range while reset = 0.
- fault[1] SHALL be set when data_read or data_write is asserted with an out-of-range data_address.
REQ-016 data_read and data_write both asserted in one cycle SHALL set fault[1]. The write SHALL still occur if in range, and readdata SHALL follow REQ-011.
REQ-017 When init_mem = 1 and reset = 0, init_word SHALL be written to the store selected by init_sel, at that store's load pointer.
- That pointer SHALL then increment, wrapping depth-1 -> 0.
- Wrapping SHALL set the matching init_full bit, which stays set until reset.
REQ-018 The two load pointers SHALL be independent; interleaving init_sel values SHALL continue each pointer from where it stopped.

Reset
REQ-019 On reset, the following SHALL be cleared to 0: both load pointers, init_full, fault and write_count.
REQ-020 Store contents SHALL be retained across reset, so a program loaded before reset survives it.
REQ-021 init_mem asserted during reset SHALL be ignored: no write, no pointer movement.
REQ-022 Deasserting reset mid-load SHALL restart loading at word 0.

Structure
REQ-023 The shared package SHALL hold the reset-vector constant 32'hBFC00000, the byte-lane width (8) and the fault bit indices.
REQ-024 One sub-module, word_store, SHALL be instantiated twice (instruction and data). It SHALL be parametrised by depth and provide:
- one combinational read port;
- one byte-enabled synchronous write port;
- an internal auto-incrementing load pointer with a wrap flag.

Verification
REQ-025 Load: reset, then pulse init_mem with init_sel = 0 and words 32'h8C230000, 32'h04410002 -> instr_address BFC00000 reads 8C230000, BFC00004 reads 04410002, fault = 0.
REQ-026 Byte write: write 32'hDEADBEEF to data 0x10 with enable 4'b1111, then 32'h00000055 with enable 4'b0001 -> read at 0x10 returns 32'hDEADBE55 and write_count = 2.
REQ-027 Out-of-range and misalignment: instr_address = 32'hBFC00002 -> instr_readdata 0 and fault[0] = 1 on the next edge; data read at DATA_BASE + 4*DATA_WORDS -> data_readdata 0 and fault[1] = 1; both flags stay set until reset.
REQ-028 Wrap: with INSTR_WORDS = 4, five instruction loads of values 1..5 -> word 0 = 5, words 1..3 = 2..4, init_full[0] = 1, init_full[1] = 0.
REQ-029 Collision and saturation:
- Write 32'h11111111 to data 0x0 while reading 0x0 -> same cycle reads the old value, next cycle reads 32'h11111111.
- A CPU write concurrent with init_mem -> discarded.
- 65540 writes -> write_count = 16'hFFFF.
REQ-030 Reset mid-load: load 2 data words, pulse reset, load 32'hCAFEF00D -> data word 0 = CAFEF00D, word 1 retains its old value, write_count = 0.
